// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared types and helpers for the CVP14 multicycle core.
// Holds the opcode and FSM state encodings, instruction field positions,
// the default reset PC and the sign-extension helpers used for immediates.
package cvp14_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_LLB  = 4'h8,
        OP_LHB  = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_BZ   = 4'hC,
        OP_J    = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_LD_WB  = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Instruction field positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 9;
    localparam int RS_MSB = 8;
    localparam int RS_LSB = 6;
    localparam int RT_MSB = 5;
    localparam int RT_LSB = 3;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/cvp14_alu.sv
// cvp14_alu: combinational ALU for the register/shift opcodes (0..7).
// Optional build macro CVP14_SAT_EN: when defined, ADD/SUB saturate on
// signed overflow instead of wrapping; overflow is reported either way.
module cvp14_alu
    import cvp14_pkg::*;
(
    input  opcode_e     op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [3:0]  shamt_i,
    output logic [15:0] result_o,
    output logic        ovf_o
);

    logic [15:0] sum;
    logic [15:0] diff;
    logic        add_ovf;
    logic        sub_ovf;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    // Overflow when operand signs make the true result unrepresentable
    assign add_ovf = (a_i[15] == b_i[15]) && (sum[15]  != a_i[15]);
    assign sub_ovf = (a_i[15] != b_i[15]) && (diff[15] != a_i[15]);

    // Result select; overflow is only meaningful for ADD/SUB
    always_comb begin
        result_o = 16'h0000;
        ovf_o    = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum;
                ovf_o    = add_ovf;
            end
            OP_SUB: begin
                result_o = diff;
                ovf_o    = sub_ovf;
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt_i;
            OP_SRL:  result_o = a_i >> shamt_i;
            OP_SRA:  result_o = 16'($signed(a_i) >>> shamt_i);
            default: result_o = 16'h0000;
        endcase
`ifdef CVP14_SAT_EN
        // On overflow the sign of a_i gives the direction of the true result
        if (ovf_o) begin
            result_o = a_i[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

endmodule

// File: rtl/cvp14_core.sv
// cvp14_core: 16-bit multicycle CVP14 core on a shared single-port RAM bus.
// FETCH reads the instruction; DECODE executes directly from DataIn; loads
// and stores take extra MEM_RD/LD_WB or MEM_WR cycles. V is sticky.
// Build option CVP14_SAT_EN (inside cvp14_alu) saturates ADD/SUB.
module cvp14_core
    import cvp14_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] DataIn,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic        V,
    output logic [15:0] dataOut
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ea_q, ea_d;
    logic        v_q, v_d;
    logic [15:0] rf_q [8];

    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_dout;

    // Decode fields come straight off the bus during DECODE
    opcode_e     dec_op;
    logic [2:0]  dec_rd, dec_rs, dec_rt, ir_rd;
    logic [15:0] dec_rd_val, rs_val, rt_val, ir_rd_val;
    logic [15:0] pc_inc;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic        unused_ir;

    assign dec_op = opcode_e'(DataIn[OP_MSB:OP_LSB]);
    assign dec_rd = DataIn[RD_MSB:RD_LSB];
    assign dec_rs = DataIn[RS_MSB:RS_LSB];
    assign dec_rt = DataIn[RT_MSB:RT_LSB];
    assign ir_rd  = ir_q[RD_MSB:RD_LSB];

    // R0 always reads as zero, including as store data or branch test
    assign dec_rd_val = (dec_rd == 3'd0) ? 16'h0000 : rf_q[dec_rd];
    assign rs_val     = (dec_rs == 3'd0) ? 16'h0000 : rf_q[dec_rs];
    assign rt_val     = (dec_rt == 3'd0) ? 16'h0000 : rf_q[dec_rt];
    assign ir_rd_val  = (ir_rd  == 3'd0) ? 16'h0000 : rf_q[ir_rd];

    assign pc_inc    = pc_q + 16'd1;
    assign unused_ir = ^{ir_q[OP_MSB:OP_LSB], ir_q[RS_MSB:0]};

    cvp14_alu u_alu (
        .op_i     (dec_op),
        .a_i      (rs_val),
        .b_i      (rt_val),
        .shamt_i  (DataIn[3:0]),
        .result_o (alu_result),
        .ovf_o    (alu_ovf)
    );

    // Control registers; reset aborts whatever instruction is in flight
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            ea_q    <= 16'h0000;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            v_q     <= v_d;
        end
    end

    // Register file; writes to R0 are dropped
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (rf_we && (rf_waddr != 3'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Next-state, execute and bus drive for each FSM state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ea_d     = ea_q;
        v_d      = v_q;
        rf_we    = 1'b0;
        rf_waddr = ir_rd;
        rf_wdata = 16'h0000;
        bus_addr = 16'h0000;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_dout = 16'h0000;
        case (state_q)
            S_FETCH: begin
                bus_addr = pc_q;
                bus_rd   = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = DataIn;
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (dec_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_XOR, OP_SLL, OP_SRL, OP_SRA: begin
                        rf_we    = 1'b1;
                        rf_waddr = dec_rd;
                        rf_wdata = alu_result;
                        v_d      = v_q | alu_ovf;
                    end
                    OP_LLB: begin
                        rf_we    = 1'b1;
                        rf_waddr = dec_rd;
                        rf_wdata = sext8(DataIn[7:0]);
                    end
                    OP_LHB: begin
                        rf_we    = 1'b1;
                        rf_waddr = dec_rd;
                        rf_wdata = {DataIn[7:0], dec_rd_val[7:0]};
                    end
                    OP_LD: begin
                        ea_d    = rs_val + sext6(DataIn[5:0]);
                        state_d = S_MEM_RD;
                    end
                    OP_ST: begin
                        ea_d    = rs_val + sext6(DataIn[5:0]);
                        state_d = S_MEM_WR;
                    end
                    OP_BZ: begin
                        if (dec_rd_val == 16'h0000) begin
                            pc_d = pc_inc + sext9(DataIn[8:0]);
                        end
                    end
                    OP_J:    pc_d = pc_inc + sext12(DataIn[11:0]);
                    OP_HALT: state_d = S_HALT;
                    default: ; // NOP
                endcase
            end
            S_MEM_RD: begin
                bus_addr = ea_q;
                bus_rd   = 1'b1;
                state_d  = S_LD_WB;
            end
            S_LD_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ir_rd;
                rf_wdata = DataIn;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                bus_addr = ea_q;
                bus_dout = ir_rd_val;
                bus_wr   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by Reset so an aborted store never reaches RAM
    assign Addr    = Reset ? 16'h0000 : bus_addr;
    assign RD      = bus_rd & ~Reset;
    assign WR      = bus_wr & ~Reset;
    assign dataOut = Reset ? 16'h0000 : bus_dout;
    assign V       = v_q;

endmodule

// File: tb/tb_cvp14_core.sv
// tb_cvp14_core: directed programs for the CVP14 core with a bus scoreboard.
// Expected bus events (kind, cycle gap, V, address, write data) are queued
// by hand; a monitor pops and compares every RD/WR cycle the core presents.
module tb_cvp14_core;

    localparam int W = 39;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_WR = 2'd2;
    localparam logic [15:0] HALT = 16'hF000;
`ifdef CVP14_SAT_EN
    localparam logic [15:0] ADD_RES = 16'h7FFF;
    localparam logic [15:0] SUB_RES = 16'h8000;
`else
    localparam logic [15:0] ADD_RES = 16'hFEFE;
    localparam logic [15:0] SUB_RES = 16'h0101;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] DataIn;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic        V;
    logic [15:0] dataOut;

    always #5 Clk1 = ~Clk1;

    cvp14_core dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .DataIn  (DataIn),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .V       (V),
        .dataOut (dataOut)
    );

    // ---------------- synchronous RAM model ----------------
    logic [15:0] mem [65536];
    logic [15:0] image [256];
    logic        ld_en = 1'b0;

    always @(posedge Clk1) begin
        if (ld_en) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            for (int i = 0; i < 256; i++) mem[i] <= image[i];
        end else begin
            if (WR) mem[Addr] <= dataOut;
            if (RD) DataIn <= mem[Addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [1:0]   last_kind = 2'd0;
    logic         exp_v = 1'b0;
    bit           mon_en = 1'b0;
    int           since_last = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [3:0] gap_after(input logic [1:0] k);
        case (k)
            K_RD:    return 4'd2;
            K_WR:    return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    task automatic push_ev(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({kind, gap_after(last_kind), exp_v, a, d});
        last_kind = kind;
    endtask

    task automatic push_rd(input logic [15:0] a);
        push_ev(K_RD, a, 16'h0000);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        push_ev(K_WR, a, d);
    endtask

    task automatic push_fetches(input int first, input int last);
        for (int p = first; p <= last; p++) push_rd(16'(p));
    endtask

    // Monitor: samples 1 time unit after the falling edge
    always @(negedge Clk1) begin
        #1;
        if (mon_en) begin
            since_last++;
            if (RD || WR) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_bus: RD=%0b WR=%0b Addr=0x%0h, expected none", RD, WR, Addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bus_kind", {62'd0, WR, RD}, {62'd0, mon_e[38:37]});
                    chk("bus_addr", {48'd0, Addr}, {48'd0, mon_e[31:16]});
                    if (mon_e[38:37] == K_WR) chk("wr_data", {48'd0, dataOut}, {48'd0, mon_e[15:0]});
                    chk("flag_v", {63'd0, V}, {63'd0, mon_e[32]});
                    if (mon_e[36:33] != 4'd0) chk("cycle_gap", 64'(since_last), {60'd0, mon_e[36:33]});
                end
                since_last = 0;
            end
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] i_rrr(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction
    function automatic logic [15:0] i_sh(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [3:0] sh);
        return {op, rd, rs, 2'b00, sh};
    endfunction
    function automatic logic [15:0] i_mem(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction
    function automatic logic [15:0] i_imm8(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] i_bz(input logic [2:0] rd, input logic [8:0] off);
        return {4'hC, rd, off};
    endfunction
    function automatic logic [15:0] i_j(input logic [11:0] off);
        return {4'hD, off};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_reset();
        mon_en = 1'b0;
        @(negedge Clk1);
        Reset = 1'b1;
        last_kind = 2'd0;
        exp_v = 1'b0;
        for (int i = 0; i < 256; i++) image[i] = HALT;
    endtask

    task automatic end_reset();
        ld_en = 1'b1;
        @(negedge Clk1);
        ld_en = 1'b0;
        @(negedge Clk1);
        chk("rst_rd", {63'd0, RD}, 64'd0);
        chk("rst_wr", {63'd0, WR}, 64'd0);
        chk("rst_v", {63'd0, V}, 64'd0);
        chk("rst_addr", {48'd0, Addr}, 64'd0);
        chk("rst_dout", {48'd0, dataOut}, 64'd0);
        since_last = 0;
        mon_en = 1'b1;
        Reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge Clk1);
            c++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string name);
        int seen;
        seen = 0;
        repeat (20) begin
            @(negedge Clk1);
            #2;
            if (RD || WR) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Program A: ALU ops, overflow/V, R0 behaviour, HALT
        start_reset();
        image[0]  = i_imm8(4'h8, 3'd1, 8'h7F);      // LLB R1,7F
        image[1]  = i_imm8(4'h9, 3'd1, 8'h7F);      // LHB R1,7F -> 7F7F
        image[2]  = i_imm8(4'h8, 3'd4, 8'hF0);      // LLB R4,F0 -> FFF0
        image[3]  = i_rrr(4'h2, 3'd5, 3'd1, 3'd4);  // AND
        image[4]  = i_mem(4'hB, 3'd5, 3'd4, 6'd1);
        image[5]  = i_rrr(4'h3, 3'd5, 3'd1, 3'd4);  // OR
        image[6]  = i_mem(4'hB, 3'd5, 3'd4, 6'd2);
        image[7]  = i_rrr(4'h4, 3'd5, 3'd1, 3'd4);  // XOR
        image[8]  = i_mem(4'hB, 3'd5, 3'd4, 6'd3);
        image[9]  = i_sh(4'h5, 3'd5, 3'd4, 4'd4);   // SLL
        image[10] = i_mem(4'hB, 3'd5, 3'd4, 6'd4);
        image[11] = i_sh(4'h6, 3'd5, 3'd4, 4'd4);   // SRL
        image[12] = i_mem(4'hB, 3'd5, 3'd4, 6'd5);
        image[13] = i_sh(4'h7, 3'd5, 3'd4, 4'd4);   // SRA
        image[14] = i_mem(4'hB, 3'd5, 3'd4, 6'd6);
        image[15] = i_rrr(4'h1, 3'd5, 3'd1, 3'd4);  // SUB, no overflow
        image[16] = i_mem(4'hB, 3'd5, 3'd4, 6'd7);
        image[17] = i_rrr(4'h0, 3'd2, 3'd1, 3'd1);  // ADD R2,R1,R1 overflow
        image[18] = i_mem(4'hB, 3'd2, 3'd4, 6'd8);
        image[19] = i_imm8(4'h8, 3'd6, 8'h80);      // FF80
        image[20] = i_imm8(4'h9, 3'd6, 8'h80);      // 8080
        image[21] = i_rrr(4'h1, 3'd7, 3'd6, 3'd1);  // SUB negative overflow
        image[22] = i_mem(4'hB, 3'd7, 3'd4, 6'd9);
        image[23] = i_imm8(4'h8, 3'd0, 8'h12);      // LLB R0 ignored
        image[24] = i_mem(4'hB, 3'd0, 3'd1, 6'h3F); // ST R0,[R1-1]
        image[25] = HALT;
        push_fetches(0, 4);  push_wr(16'hFFF1, 16'h7F70);
        push_fetches(5, 6);  push_wr(16'hFFF2, 16'hFFFF);
        push_fetches(7, 8);  push_wr(16'hFFF3, 16'h808F);
        push_fetches(9, 10); push_wr(16'hFFF4, 16'hFF00);
        push_fetches(11, 12); push_wr(16'hFFF5, 16'h0FFF);
        push_fetches(13, 14); push_wr(16'hFFF6, 16'hFFFF);
        push_fetches(15, 16); push_wr(16'hFFF7, 16'h7F8F);
        push_fetches(17, 17);
        exp_v = 1'b1;
        push_fetches(18, 18); push_wr(16'hFFF8, ADD_RES);
        push_fetches(19, 22); push_wr(16'hFFF9, SUB_RES);
        push_fetches(23, 24); push_wr(16'h7F7E, 16'h0000);
        push_fetches(25, 25);
        end_reset();
        wait_drain(400);
        check_quiet("halt_quiet_a");

        // Program B: store/load, read-after-write, branches, jump loop
        start_reset();
        image[0]  = i_imm8(4'h8, 3'd3, 8'h10);
        image[1]  = i_imm8(4'h8, 3'd4, 8'h55);
        image[2]  = i_mem(4'hB, 3'd4, 3'd3, 6'd2);   // ST R4,[R3+2]
        image[3]  = i_mem(4'hA, 3'd5, 3'd3, 6'd2);   // LD R5,[R3+2]
        image[4]  = i_mem(4'hB, 3'd5, 3'd3, 6'd3);
        image[5]  = i_bz(3'd0, 9'd3);                // taken -> 9
        image[9]  = i_bz(3'd3, 9'd3);                // not taken -> 10
        image[10] = i_mem(4'hA, 3'd6, 3'd3, 6'h3F);  // LD R6,[R3-1]
        image[11] = i_mem(4'hB, 3'd6, 3'd3, 6'd4);
        image[12] = i_j(12'd1);                      // -> 14
        image[14] = i_j(12'hFFF);                    // loops at 14
        image[15] = 16'hA5C3;
        push_fetches(0, 2);  push_wr(16'h0012, 16'h0055);
        push_fetches(3, 3);  push_rd(16'h0012);
        push_fetches(4, 4);  push_wr(16'h0013, 16'h0055);
        push_fetches(5, 5);
        push_fetches(9, 10); push_rd(16'h000F);
        push_fetches(11, 11); push_wr(16'h0014, 16'hA5C3);
        push_fetches(12, 12);
        for (int k = 0; k < 4; k++) push_rd(16'h000E);
        end_reset();
        wait_drain(400);

        // Program C: reset during a load, then a clean rerun
        start_reset();
        image[0]  = i_mem(4'hB, 3'd1, 3'd0, 6'h1C);  // ST R1,[1C]
        image[1]  = i_mem(4'hA, 3'd1, 3'd0, 6'h18);  // LD R1,[18]
        image[2]  = i_mem(4'hB, 3'd1, 3'd0, 6'h1D);  // ST R1,[1D]
        image[24] = 16'hBEEF;
        push_fetches(0, 0); push_wr(16'h001C, 16'h0000);
        push_fetches(1, 1); push_rd(16'h0018);
        end_reset();
        wait_drain(100);
        start_reset();  // asserted during LD_WB
        image[0]  = i_mem(4'hB, 3'd1, 3'd0, 6'h1C);
        image[1]  = i_mem(4'hA, 3'd1, 3'd0, 6'h18);
        image[2]  = i_mem(4'hB, 3'd1, 3'd0, 6'h1D);
        image[24] = 16'hBEEF;
        push_fetches(0, 0); push_wr(16'h001C, 16'h0000);
        push_fetches(1, 1); push_rd(16'h0018);
        push_fetches(2, 2); push_wr(16'h001D, 16'hBEEF);
        push_fetches(3, 3);
        end_reset();
        wait_drain(200);
        check_quiet("halt_quiet_c");

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
